// File: rtl/fwd_pkg.sv
// Shared encodings and helpers for the forwarding/hazard unit.
// The select function keeps the MEM-over-WB priority in one place.
package fwd_pkg;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // Register 0 never forwards; MEM holds the younger result, so it wins over WB.
  function automatic logic [1:0] fwdSelect(input logic srcZero,
                                           input logic memHit,
                                           input logic wbHit);
    if (srcZero) return SEL_RF;
    if (memHit) return SEL_MEM;
    if (wbHit) return SEL_WB;
    return SEL_RF;
  endfunction

endpackage

// File: rtl/fwd_scoreboard.sv
// Per-register latency scoreboard: counts cycles until each destination
// becomes forwardable and reports which queried sources are still pending.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int RW    = 5,
  parameter int NSRC  = 2,
  parameter int LAT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue,
  input  logic [RW-1:0]        issueRd,
  input  logic [LAT_W-1:0]     issueLat,
  input  logic [NSRC*RW-1:0]   queryRs,
  output logic [NSRC-1:0]      pending
);

  localparam int NREG = 2 ** RW;

  logic [LAT_W-1:0] cnt     [NREG];
  logic [LAT_W-1:0] cntNext [NREG];
  logic [LAT_W-1:0] latEff;

  always_comb begin
    latEff = (issueLat == '0) ? LAT_W'(LAT_ALU) : issueLat;
  end

  // Issue takes the larger of the decremented count and the new latency,
  // so a short-latency write never overtakes an older long one.
  always_comb begin
    cntNext[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      cntNext[r] = (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : '0;
      if (issue && (issueRd == RW'(r)) && (latEff > cntNext[r])) begin
        cntNext[r] = latEff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= cntNext[r];
      end
    end
  end

  // A count of 1 is covered by MEM forwarding, so only larger counts are pending.
  always_comb begin
    pending = '0;
    for (int k = 0; k < NSRC; k++) begin
      pending[k] = (queryRs[k*RW +: RW] != '0) &&
                   (cnt[queryRs[k*RW +: RW]] > LAT_W'(1));
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects for EX operands plus scoreboard-driven ID stall
// and a saturating count of stalled cycles.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int RW    = 5,
  parameter int NSRC  = 2,
  parameter int LAT_W = 3,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NSRC*RW-1:0]   id_rs,
  input  logic                 id_wr,
  input  logic [RW-1:0]        id_rd,
  input  logic [LAT_W-1:0]     id_lat,
  input  logic                 flush,
  input  logic                 mem_wb,
  input  logic [RW-1:0]        mem_rd,
  input  logic                 wb_wb,
  input  logic [RW-1:0]        wb_rd,
  input  logic [NSRC*RW-1:0]   ex_rs,
  output logic [NSRC*2-1:0]    sel,
  output logic                 stall,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic [NSRC-1:0] pending;
  logic            issue;

  always_comb begin
    sel = '0;
    for (int k = 0; k < NSRC; k++) begin
      sel[k*2 +: 2] = fwdSelect(ex_rs[k*RW +: RW] == '0,
                                mem_wb && (mem_rd == ex_rs[k*RW +: RW]),
                                wb_wb && (wb_rd == ex_rs[k*RW +: RW]));
    end
  end

  // Stall reads pre-issue counts; a stalled or flushed instruction never issues.
  always_comb begin
    stall = id_valid && !flush && (|pending);
    issue = id_valid && !stall && !flush && id_wr && (id_rd != '0);
  end

  fwd_scoreboard #(
    .RW    (RW),
    .NSRC  (NSRC),
    .LAT_W (LAT_W)
  ) scoreboard (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .issueRd  (id_rd),
    .issueLat (id_lat),
    .queryRs  (id_rs),
    .pending  (pending)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and randomized checks of fwd_hazard_unit against a model that
// tracks, per register, the absolute cycle at which its result is ready.
module tb_fwd_hazard_unit;

  localparam int RW      = 5;
  localparam int NSRC    = 2;
  localparam int LAT_W   = 3;
  localparam int CNT_W   = 6;
  localparam int NREG    = 2 ** RW;
  localparam int CNT_MAX = 2 ** CNT_W - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                id_valid = 1'b0;
  logic [NSRC*RW-1:0]  id_rs = '0;
  logic                id_wr = 1'b0;
  logic [RW-1:0]       id_rd = '0;
  logic [LAT_W-1:0]    id_lat = '0;
  logic                flush = 1'b0;
  logic                mem_wb = 1'b0;
  logic [RW-1:0]       mem_rd = '0;
  logic                wb_wb = 1'b0;
  logic [RW-1:0]       wb_rd = '0;
  logic [NSRC*RW-1:0]  ex_rs = '0;
  logic [NSRC*2-1:0]   sel;
  logic                stall;
  logic [CNT_W-1:0]    stall_cnt;

  int checks = 0;
  int errors = 0;
  int readyAt [NREG];
  int now = 0;
  int modelStallCnt = 0;

  fwd_hazard_unit #(
    .RW    (RW),
    .NSRC  (NSRC),
    .LAT_W (LAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_wr     (id_wr),
    .id_rd     (id_rd),
    .id_lat    (id_lat),
    .flush     (flush),
    .mem_wb    (mem_wb),
    .mem_rd    (mem_rd),
    .wb_wb     (wb_wb),
    .wb_rd     (wb_rd),
    .ex_rs     (ex_rs),
    .sel       (sel),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [NSRC*RW-1:0] pack2(input int src1, input int src0);
    return {RW'(src1), RW'(src0)};
  endfunction

  function automatic int remaining(input int r);
    if (r == 0) return 0;
    return (readyAt[r] > now) ? readyAt[r] - now : 0;
  endfunction

  function automatic logic expectStall();
    if (!rst || !id_valid || flush) return 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (id_rs[k*RW +: RW] != '0 && remaining(int'(id_rs[k*RW +: RW])) > 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] expectSel(input logic [RW-1:0] s);
    if (s == '0) return 2'b00;
    if (mem_wb && mem_rd == s) return 2'b01;
    if (wb_wb && wb_rd == s) return 2'b10;
    return 2'b00;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    #1;
    for (int k = 0; k < NSRC; k++) begin
      check($sformatf("%s.sel%0d", tag, k), 32'(sel[k*2 +: 2]), 32'(expectSel(ex_rs[k*RW +: RW])));
    end
    check({tag, ".stall"}, 32'(stall), 32'(expectStall()));
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(modelStallCnt));
  endtask

  task automatic applyStimulus(input logic valid, input logic [NSRC*RW-1:0] rs, input logic wr,
                               input int rd, input int lat, input logic fl);
    id_valid = valid;
    id_rs    = rs;
    id_wr    = wr;
    id_rd    = RW'(rd);
    id_lat   = LAT_W'(lat);
    flush    = fl;
  endtask

  task automatic setForward(input logic mwb, input int mrd, input logic wwb, input int wrd,
                            input logic [NSRC*RW-1:0] exs);
    mem_wb = mwb;
    mem_rd = RW'(mrd);
    wb_wb  = wwb;
    wb_rd  = RW'(wrd);
    ex_rs  = exs;
  endtask

  // Advance one clock edge and apply the scoreboard rules to the model.
  task automatic tick();
    logic st;
    int lat;
    int rd;
    st = expectStall();
    @(posedge clk);
    if (rst) begin
      if (st && modelStallCnt < CNT_MAX) modelStallCnt++;
      rd = int'(id_rd);
      if (id_valid && !st && !flush && id_wr && rd != 0) begin
        lat = (id_lat == '0) ? 1 : int'(id_lat);
        if (now + 1 + lat > readyAt[rd]) readyAt[rd] = now + 1 + lat;
      end
    end
    now++;
    #1;
  endtask

  task automatic clearModel();
    for (int r = 0; r < NREG; r++) readyAt[r] = 0;
    modelStallCnt = 0;
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    #1;
    clearModel();
    rst = 1'b1;
  endtask

  initial begin
    clearModel();
    #2;
    checkOutput("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Forwarding priority
    setForward(1'b1, 8, 1'b1, 8, pack2(8, 8));
    checkOutput("fwdMem");
    check("fwdMemConst", 32'(sel), 32'(4'b0101));
    mem_wb = 1'b0;
    checkOutput("fwdWb");
    check("fwdWbConst", 32'(sel), 32'(4'b1010));
    ex_rs = pack2(0, 0);
    checkOutput("fwdZero");
    check("fwdZeroConst", 32'(sel), 32'(4'b0000));
    setForward(1'b0, 0, 1'b0, 0, pack2(0, 0));

    // Load-use
    pulseReset();
    applyStimulus(1'b1, pack2(0, 0), 1'b1, 3, 2, 1'b0);
    checkOutput("loadIssue");
    tick();
    applyStimulus(1'b1, pack2(3, 0), 1'b0, 0, 0, 1'b0);
    checkOutput("loadUse0");
    check("loadUseStall", 32'(stall), 32'd1);
    tick();
    checkOutput("loadUse1");
    check("loadUseRelease", 32'(stall), 32'd0);
    check("loadUseCnt", 32'(stall_cnt), 32'd1);
    tick();

    // Multi-cycle producer
    pulseReset();
    applyStimulus(1'b1, pack2(0, 0), 1'b1, 5, 4, 1'b0);
    checkOutput("multiIssue");
    tick();
    applyStimulus(1'b1, pack2(0, 5), 1'b0, 0, 0, 1'b0);
    repeat (4) begin
      checkOutput("multiUse");
      tick();
    end
    check("multiCnt", 32'(stall_cnt), 32'd3);

    // Write-after-write ordering
    pulseReset();
    applyStimulus(1'b1, pack2(0, 0), 1'b1, 6, 4, 1'b0);
    checkOutput("wawFirst");
    tick();
    applyStimulus(1'b1, pack2(0, 0), 1'b1, 6, 1, 1'b0);
    checkOutput("wawSecond");
    tick();
    applyStimulus(1'b1, pack2(6, 0), 1'b0, 0, 0, 1'b0);
    repeat (3) begin
      checkOutput("wawUse");
      tick();
    end
    check("wawCnt", 32'(stall_cnt), 32'd2);

    // Flush and register 0
    pulseReset();
    applyStimulus(1'b1, pack2(0, 0), 1'b1, 7, 4, 1'b1);
    checkOutput("flushIssue");
    tick();
    applyStimulus(1'b1, pack2(0, 7), 1'b0, 0, 0, 1'b0);
    checkOutput("flushUse");
    check("flushNoStall", 32'(stall), 32'd0);
    tick();
    applyStimulus(1'b1, pack2(0, 0), 1'b1, 0, 4, 1'b0);
    checkOutput("r0Issue");
    tick();
    applyStimulus(1'b1, pack2(0, 0), 1'b0, 0, 0, 1'b0);
    checkOutput("r0Use");
    check("r0NoStall", 32'(stall), 32'd0);
    tick();
    applyStimulus(1'b1, pack2(0, 0), 1'b1, 2, 4, 1'b0);
    tick();
    applyStimulus(1'b1, pack2(2, 0), 1'b0, 0, 0, 1'b1);
    checkOutput("flushStalled");
    check("flushForcesZero", 32'(stall), 32'd0);
    tick();

    // Asynchronous reset mid-stall
    pulseReset();
    applyStimulus(1'b1, pack2(0, 0), 1'b1, 5, 4, 1'b0);
    checkOutput("arstIssue");
    tick();
    applyStimulus(1'b1, pack2(0, 5), 1'b0, 0, 0, 1'b0);
    checkOutput("arstStall");
    tick();
    checkOutput("arstStall2");
    rst = 1'b0;
    #1;
    check("arstStallDrop", 32'(stall), 32'd0);
    check("arstCntDrop", 32'(stall_cnt), 32'd0);
    clearModel();
    #1;
    rst = 1'b1;
    checkOutput("arstAfter");
    tick();
    checkOutput("arstAfter2");
    check("arstNoStall", 32'(stall), 32'd0);
    tick();

    // Saturation of the stall counter
    pulseReset();
    repeat (12) begin
      applyStimulus(1'b1, pack2(0, 0), 1'b1, 1, 7, 1'b0);
      checkOutput("satIssue");
      tick();
      applyStimulus(1'b1, pack2(0, 1), 1'b0, 0, 0, 1'b0);
      repeat (7) begin
        checkOutput("satUse");
        tick();
      end
    end
    check("satValue", 32'(stall_cnt), 32'(CNT_MAX));

    // Randomized traffic
    pulseReset();
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    pack2($urandom_range(0, 7), $urandom_range(0, 7)),
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7),
                    $urandom_range(0, 7),
                    $urandom_range(0, 7) == 0);
      setForward($urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 pack2($urandom_range(0, 7), $urandom_range(0, 7)));
      checkOutput("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
